// File: rtl/alu_exec_if.sv
// Handshake bundle between alucontrol-side producer and the execute unit.
// The producer drives operands on the input side and consumes the result on the output side.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opselector;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, opselector, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, opselector, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ADD/SUB/AND/OR/SLT and an iterative one-bit-per-cycle SLL,
// with valid/ready on both sides and registered result, zero and overflow flags.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic               accept_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic [WIDTH-1:0]   sum_c;
  logic [WIDTH-1:0]   diff_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_ovf_c;
  logic [WIDTH-1:0]   work_d;
  logic               is_shift_c;

  assign accept_c   = bus.in_valid & in_ready_q;
  assign shamt_c    = bus.b[SHAMT_W-1:0];
  assign sum_c      = bus.a + bus.b;
  assign diff_c     = bus.a - bus.b;
  assign work_d     = work_q << 1;
  assign is_shift_c = (bus.opselector == 3'b111) && (shamt_c != '0);

  // Single-cycle result; SLL with zero shift amount falls through as a pass of operand A.
  always_comb begin
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    case (bus.opselector)
      3'b000, 3'b100: begin
        alu_res_c = sum_c;
        alu_ovf_c = (bus.a[MSB] == bus.b[MSB]) && (sum_c[MSB] != bus.a[MSB]);
      end
      3'b001, 3'b101: begin
        alu_res_c = diff_c;
        alu_ovf_c = (bus.a[MSB] != bus.b[MSB]) && (diff_c[MSB] != bus.a[MSB]);
      end
      3'b010:  alu_res_c = bus.a & bus.b;
      3'b011:  alu_res_c = bus.a | bus.b;
      3'b110:  alu_res_c = WIDTH'($signed(bus.a) < $signed(bus.b));
      default: alu_res_c = bus.a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            in_ready_q <= 1'b0;
            if (is_shift_c) begin
              work_q  <= bus.a;
              cnt_q   <= shamt_c;
              state_q <= SHIFT;
            end else begin
              result_q    <= alu_res_c;
              zero_q      <= (alu_res_c == '0);
              ovf_q       <= alu_ovf_c;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - SHAMT_W'(1);
          // Last shift lands directly in the result so DONE starts with stable outputs.
          if (cnt_q == SHAMT_W'(1)) begin
            result_q    <= work_d;
            zero_q      <= (work_d == '0);
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_exec_if #(.WIDTH(16)) bus ();

  alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer arithmetic with explicit range test for overflow.
  function automatic void model(input logic [2:0] op, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] r,
                                output logic ov);
    int    sa;
    int    sb;
    int    t;
    longint p;
    logic [3:0] sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[3:0];
    r  = 16'h0;
    ov = 1'b0;
    case (op)
      3'd0, 3'd4: begin t = sa + sb; r = 16'(t); ov = (t > 32767) || (t < -32768); end
      3'd1, 3'd5: begin t = sa - sb; r = 16'(t); ov = (t > 32767) || (t < -32768); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd6: r = (sa < sb) ? 16'd1 : 16'd0;
      default: begin p = longint'(a) * (longint'(1) << sh); r = 16'(p % 65536); end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int hold,
                        input logic [15:0] exp_r, input logic exp_ov);
    int lat;
    int exp_lat;
    logic [15:0] r0;
    exp_lat = (op == 3'd7) ? 1 + int'(b[3:0]) : 1;
    @(negedge clk);
    chk({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.opselector = op;
    bus.a          = a;
    bus.b          = b;
    bus.out_ready  = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"},  32'(bus.result), 32'(exp_r));
    chk({tag, "_zero"},    32'(bus.zero), 32'(exp_r == 16'h0));
    chk({tag, "_ovf"},     32'(bus.overflow), 32'(exp_ov));
    r0 = bus.result;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid   = 1'b1;
      bus.opselector = 3'($urandom_range(0, 7));
      bus.a          = 16'($urandom);
      bus.b          = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"},  32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_result"}, 32'(bus.result), 32'(r0));
      chk({tag, "_hold_ready"},  32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  logic [2:0]  rop;
  logic [15:0] ra;
  logic [15:0] rb;
  logic [15:0] er;
  logic        eo;
  logic [2:0]  q_op [4];
  logic [15:0] q_a  [4];
  logic [15:0] q_b  [4];
  int          idx;
  int          got;
  int          last_acc;
  logic        acc;

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.opselector = 3'd0;
    bus.a          = 16'h0;
    bus.b          = 16'h0;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.result), 32'd0);
    chk("rst_zero",      32'(bus.zero), 32'd0);
    chk("rst_ovf",       32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready",  32'(bus.in_ready), 32'd1);

    run_op("add_ovf",  3'd0, 16'h7FFF, 16'h0001, 0, 16'h8000, 1'b1);
    run_op("beq",      3'd5, 16'h1234, 16'h1234, 3, 16'h0000, 1'b0);
    run_op("slt",      3'd6, 16'hFFFE, 16'h0003, 0, 16'h0001, 1'b0);
    run_op("sll15",    3'd7, 16'h0001, 16'h000F, 0, 16'h8000, 1'b0);
    run_op("sll0",     3'd7, 16'h0001, 16'h0000, 0, 16'h0001, 1'b0);
    run_op("sub_ovf",  3'd1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1'b1);
    run_op("sll_zero", 3'd7, 16'h8000, 16'h0001, 0, 16'h0000, 1'b0);
    run_op("and",      3'd2, 16'hF0F0, 16'h0FF0, 0, 16'h00F0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (i % 4 == 0) ra[15] = rb[15];
      model(rop, ra, rb, er, eo);
      run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)), er, eo);
    end

    // Back-to-back stream of logic ops with the consumer always ready.
    for (int k = 0; k < 4; k++) begin
      q_op[k] = (k % 2 == 0) ? 3'd2 : 3'd3;
      q_a[k]  = 16'($urandom);
      q_b[k]  = 16'($urandom);
    end
    idx      = 0;
    got      = 0;
    last_acc = -1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && (idx < 4 || got < 4); c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (got < 4) begin
          model(q_op[got], q_a[got], q_b[got], er, eo);
          chk("b2b_result", 32'(bus.result), 32'(er));
        end
        got++;
      end
      if (idx < 4) begin
        bus.in_valid   = 1'b1;
        bus.opselector = q_op[idx];
        bus.a          = q_a[idx];
        bus.b          = q_b[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_ready & bus.in_valid;
      @(posedge clk);
      if (acc) begin
        if (idx > 0) chk("b2b_gap", 32'(c - last_acc), 32'd2);
        last_acc = c;
        idx++;
      end
    end
    chk("b2b_accepted", 32'(idx), 32'd4);
    chk("b2b_results",  32'(got), 32'd4);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Async reset in the middle of a long shift.
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.opselector = 3'd7;
    bus.a          = 16'h0001;
    bus.b          = 16'h000A;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_shift_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_shift_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_valid",  32'(bus.out_valid), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_ready",     32'(bus.in_ready), 32'd1);
    chk("abort_no_output", 32'(bus.out_valid), 32'd0);
    run_op("recover", 3'd3, 16'h00F0, 16'h0F00, 0, 16'h0FF0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
